// File: rtl/cp0_exc_ctrl_if.sv
// CP0 exception-controller bus.
// Bundles the M-stage pipeline signals (mtc0/mfc0 access, exception status,
// eret, external interrupts) and the controller's responses (Req, EPC_out,
// cp0_rdata).
//   master : pipeline side, drives requests and status, samples responses.
//   slave  : CP0 side, the mirror image.
interface cp0_exc_ctrl_if;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] M_pc;
  logic [4:0]  M_ExcCode;
  logic        M_isBD;
  logic [5:0]  hw_int;
  logic        eret;
  logic        Req;
  logic [31:0] EPC_out;

  modport master (
    output we, cp0_addr, cp0_wdata, M_pc, M_ExcCode, M_isBD, hw_int, eret,
    input  cp0_rdata, Req, EPC_out
  );

  modport slave (
    input  we, cp0_addr, cp0_wdata, M_pc, M_ExcCode, M_isBD, hw_int, eret,
    output cp0_rdata, Req, EPC_out
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception responder sitting at the M stage.
// Holds SR(12), Cause(13), EPC(14) and PRId(15). Raises Req combinationally
// for an enabled hardware interrupt or a synchronous exception, records
// EPC/BD/ExcCode on that edge and sets EXL; eret clears EXL; mtc0 writes SR
// and EPC.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : cp0_exc_ctrl_if.slave (mtc0/mfc0, M-stage exception status,
//           hw_int, eret, Req, EPC_out)
module cp0_exc_ctrl #(
  parameter logic [4:0]  EXC_NONE = 5'd0,
  parameter logic [31:0] PRID_VAL = 32'h0000_2024
) (
  input logic              clk,
  input logic              reset,
  cp0_exc_ctrl_if.slave    bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] victim_pc;
  logic [31:0] sr_view;
  logic [31:0] cause_view;

  // Only IM/EXL/IE of the write data ever land in SR.
  logic unused_wdata;
  assign unused_wdata = ^{bus.cp0_wdata[31:16], bus.cp0_wdata[9:2]};

  always_comb begin
    int_req = ie_q & ~exl_q & (|(bus.hw_int & im_q));
    exc_req = ~exl_q & (bus.M_ExcCode != EXC_NONE);
    req     = int_req | exc_req;
    // A delay-slot victim restarts at its branch; wraps modulo 2^32.
    victim_pc = bus.M_isBD ? (bus.M_pc - 32'd4) : bus.M_pc;
  end

  // Priority: Req > eret > mtc0. A mtc0 in the Req cycle belongs to the
  // faulting instruction, which never completes, so it is dropped.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      exl_d      = 1'b1;
      bd_d       = bus.M_isBD;
      exc_code_d = int_req ? 5'd0 : bus.M_ExcCode;
      epc_d      = {victim_pc[31:2], 2'b00};
    end else if (bus.eret) begin
      exl_d = 1'b0;
    end else if (bus.we) begin
      case (bus.cp0_addr)
        5'd12: begin
          im_d  = bus.cp0_wdata[15:10];
          exl_d = bus.cp0_wdata[1];
          ie_d  = bus.cp0_wdata[0];
        end
        5'd14:   epc_d = {bus.cp0_wdata[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= bus.hw_int;  // pending lines tracked every cycle
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    sr_view    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    cause_view = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b00};
    unique case (bus.cp0_addr)
      5'd12:   bus.cp0_rdata = sr_view;
      5'd13:   bus.cp0_rdata = cause_view;
      5'd14:   bus.cp0_rdata = epc_q;
      5'd15:   bus.cp0_rdata = PRID_VAL;
      default: bus.cp0_rdata = 32'b0;
    endcase
    bus.Req     = req;
    bus.EPC_out = epc_q;
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we        = 1'b0;
    bus.cp0_addr  = 5'd0;
    bus.cp0_wdata = 32'd0;
    bus.M_pc      = 32'd0;
    bus.M_ExcCode = 5'd0;
    bus.M_isBD    = 1'b0;
    bus.hw_int    = 6'd0;
    bus.eret      = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.we        = 1'b1;
    bus.cp0_addr  = addr;
    bus.cp0_wdata = data;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total_cnt++;
    if (bus.Req !== 1'b0) $display("FAIL reset_req got %b want 0", bus.Req);
    else pass_cnt++;
    total_cnt++;
    if (bus.EPC_out !== 32'd0) $display("FAIL reset_epc_out got %h want 0", bus.EPC_out);
    else pass_cnt++;
    bus.cp0_addr = 5'd12; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'd0) $display("FAIL reset_sr got %h want 0", bus.cp0_rdata);
    else pass_cnt++;
    bus.cp0_addr = 5'd13; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'd0) $display("FAIL reset_cause got %h want 0", bus.cp0_rdata);
    else pass_cnt++;
  endtask

  task automatic test_interrupt();
    mtc0(5'd12, 32'h0000_0401);
    bus.cp0_addr = 5'd12; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_0401) $display("FAIL int_sr_setup got %h want 00000401", bus.cp0_rdata);
    else pass_cnt++;
    bus.hw_int = 6'h01; bus.M_pc = 32'h0000_3010; bus.M_isBD = 1'b0; #1;
    total_cnt++;
    if (bus.Req !== 1'b1) $display("FAIL int_req got %b want 1", bus.Req);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.Req !== 1'b0) $display("FAIL int_req_masked got %b want 0", bus.Req);
    else pass_cnt++;
    idle();
    total_cnt++;
    if (bus.EPC_out !== 32'h0000_3010) $display("FAIL int_epc got %h want 00003010", bus.EPC_out);
    else pass_cnt++;
    bus.cp0_addr = 5'd13; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_0400) $display("FAIL int_cause got %h want 00000400", bus.cp0_rdata);
    else pass_cnt++;
    bus.cp0_addr = 5'd12; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_0403) $display("FAIL int_sr_exl got %h want 00000403", bus.cp0_rdata);
    else pass_cnt++;
    do_eret();
    bus.cp0_addr = 5'd12; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_0401) $display("FAIL eret_sr got %h want 00000401", bus.cp0_rdata);
    else pass_cnt++;
  endtask

  task automatic test_exception();
    bus.M_ExcCode = 5'd12; bus.M_isBD = 1'b1; bus.M_pc = 32'h0000_3024; #1;
    total_cnt++;
    if (bus.Req !== 1'b1) $display("FAIL exc_req got %b want 1", bus.Req);
    else pass_cnt++;
    tick();
    idle();
    total_cnt++;
    if (bus.EPC_out !== 32'h0000_3020) $display("FAIL exc_epc_bd got %h want 00003020", bus.EPC_out);
    else pass_cnt++;
    bus.cp0_addr = 5'd13; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h8000_0030) $display("FAIL exc_cause got %h want 80000030", bus.cp0_rdata);
    else pass_cnt++;
    do_eret();
  endtask

  task automatic test_priority();
    bus.hw_int = 6'h01; bus.M_ExcCode = 5'd4; bus.M_pc = 32'h0000_3040; #1;
    total_cnt++;
    if (bus.Req !== 1'b1) $display("FAIL prio_req got %b want 1", bus.Req);
    else pass_cnt++;
    tick();
    idle();
    bus.cp0_addr = 5'd13; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_0400) $display("FAIL prio_cause got %h want 00000400", bus.cp0_rdata);
    else pass_cnt++;
    total_cnt++;
    if (bus.EPC_out !== 32'h0000_3040) $display("FAIL prio_epc got %h want 00003040", bus.EPC_out);
    else pass_cnt++;
    do_eret();
  endtask

  task automatic test_nested();
    bus.M_ExcCode = 5'd10; bus.M_pc = 32'h0000_3050;
    tick();
    bus.hw_int = 6'h3F; #1;
    total_cnt++;
    if (bus.Req !== 1'b0) $display("FAIL nested_masked got %b want 0", bus.Req);
    else pass_cnt++;
    tick();
    bus.eret = 1'b1; bus.M_ExcCode = 5'd0; #1;
    total_cnt++;
    if (bus.Req !== 1'b0) $display("FAIL nested_eret_cycle got %b want 0", bus.Req);
    else pass_cnt++;
    tick();
    bus.eret = 1'b0; #1;
    total_cnt++;
    if (bus.Req !== 1'b1) $display("FAIL nested_pending_int got %b want 1", bus.Req);
    else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_eret_idle();
    bus.eret = 1'b1; bus.M_ExcCode = 5'd5; bus.M_pc = 32'h0000_3060; #1;
    total_cnt++;
    if (bus.Req !== 1'b1) $display("FAIL eret_idle_req got %b want 1", bus.Req);
    else pass_cnt++;
    tick();
    idle();
    bus.cp0_addr = 5'd12; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_0403) $display("FAIL eret_idle_sr got %h want 00000403", bus.cp0_rdata);
    else pass_cnt++;
    bus.cp0_addr = 5'd13; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_0014) $display("FAIL eret_idle_cause got %h want 00000014", bus.cp0_rdata);
    else pass_cnt++;
    do_eret();
  endtask

  task automatic test_mtc0();
    mtc0(5'd14, 32'h0000_3457);
    total_cnt++;
    if (bus.EPC_out !== 32'h0000_3454) $display("FAIL mtc0_epc got %h want 00003454", bus.EPC_out);
    else pass_cnt++;
    mtc0(5'd13, 32'hFFFF_FFFF);
    bus.cp0_addr = 5'd13; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_0014) $display("FAIL mtc0_cause_ro got %h want 00000014", bus.cp0_rdata);
    else pass_cnt++;
    bus.cp0_addr = 5'd15; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_2024) $display("FAIL mfc0_prid got %h want 00002024", bus.cp0_rdata);
    else pass_cnt++;
    bus.cp0_addr = 5'd7; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'd0) $display("FAIL mfc0_other got %h want 0", bus.cp0_rdata);
    else pass_cnt++;
    mtc0(5'd12, 32'hFFFF_FC01);
    bus.cp0_addr = 5'd12; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_FC01) $display("FAIL mtc0_sr_mask got %h want 0000fc01", bus.cp0_rdata);
    else pass_cnt++;
    mtc0(5'd12, 32'h0000_0401);
  endtask

  task automatic test_mtc0_in_req();
    bus.M_ExcCode = 5'd8; bus.M_pc = 32'h0000_3070;
    bus.we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'd0; #1;
    total_cnt++;
    if (bus.Req !== 1'b1) $display("FAIL req_mtc0_req got %b want 1", bus.Req);
    else pass_cnt++;
    tick();
    idle();
    bus.cp0_addr = 5'd12; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'h0000_0403) $display("FAIL req_mtc0_sr got %h want 00000403", bus.cp0_rdata);
    else pass_cnt++;
    total_cnt++;
    if (bus.EPC_out !== 32'h0000_3070) $display("FAIL req_mtc0_epc got %h want 00003070", bus.EPC_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.cp0_addr = 5'd12; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'd0) $display("FAIL midrst_sr got %h want 0", bus.cp0_rdata);
    else pass_cnt++;
    bus.cp0_addr = 5'd13; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'd0) $display("FAIL midrst_cause got %h want 0", bus.cp0_rdata);
    else pass_cnt++;
    bus.cp0_addr = 5'd14; #1;
    total_cnt++;
    if (bus.cp0_rdata !== 32'd0) $display("FAIL midrst_epc got %h want 0", bus.cp0_rdata);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bus.M_ExcCode = 5'd6; bus.M_isBD = 1'b1; bus.M_pc = 32'h0000_0002;
    tick();
    idle();
    total_cnt++;
    if (bus.EPC_out !== 32'hFFFF_FFFC) $display("FAIL wrap_epc got %h want fffffffc", bus.EPC_out);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    idle();
    test_reset();
    test_interrupt();
    test_exception();
    test_priority();
    test_nested();
    test_eret_idle();
    test_mtc0();
    test_mtc0_in_req();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
